// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control sequencer for a tiny accumulator CPU. It fetches 16-bit
//   instructions (opcode [15:12], operand [11:0]) from a synchronous RAM with a
//   one-cycle read latency, sequences LOAD/STORE/ALU/branch/immediate
//   instructions through a fixed state machine, and drives an external ALU.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse, begins execution from PC in IDLE/HALT
//   mem_addr        RAM address (MAR)
//   mem_data_out    RAM write data (AC while writing, zero otherwise)
//   mem_data_in     RAM read data, valid the cycle after a read strobe
//   mem_cs/we/oe    RAM chip select, write enable, output enable
//   alu_a, alu_b    ALU operands (AC, MBR)
//   alu_sel         ALU op: 00 add, 01 sub, 10 and, 11 or
//   alu_out         ALU result
//   pc, ac          current program counter and accumulator
//   busy            high in every state except IDLE and HALT
//   halted          high in HALT
//   illegal         sticky illegal-opcode flag, cleared by reset or restart
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int          ADDR_WIDTH = 18,
    parameter int          DATA_WIDTH = 16,
    parameter logic [15:0] RESET_PC   = 16'h0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic [15:0]           pc,
    output logic [15:0]           ac,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FETCH      = 4'd1;
    localparam logic [3:0] S_FETCH_WAIT = 4'd2;
    localparam logic [3:0] S_DECODE     = 4'd3;
    localparam logic [3:0] S_MEM_RD     = 4'd4;
    localparam logic [3:0] S_MEM_WAIT   = 4'd5;
    localparam logic [3:0] S_EXEC       = 4'd6;
    localparam logic [3:0] S_MEM_WR     = 4'd7;
    localparam logic [3:0] S_HALT       = 4'd8;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_LDI   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    logic [3:0]            state_q, state_d;
    logic [15:0]           pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic                  illegal_q, illegal_d;

    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        strobe_rd;
    logic        strobe_wr;

    assign opcode  = ir_q[15:12];
    assign operand = ir_q[11:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mbr_d     = mbr_q;
        ac_d      = ac_q;
        mar_d     = mar_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_d    = 16'(mem_data_in);
                pc_d    = pc_q + 16'd2;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:   state_d = S_FETCH;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR:
                              state_d = S_MEM_RD;
                    OP_STORE: state_d = S_MEM_WR;
                    OP_JMP: begin
                        pc_d    = {4'h0, operand};
                        state_d = S_FETCH;
                    end
                    OP_JZ: begin
                        // Not taken leaves PC at the already incremented value.
                        if (ac_q == '0) pc_d = {4'h0, operand};
                        state_d = S_FETCH;
                    end
                    OP_LDI: begin
                        ac_d    = DATA_WIDTH'(operand);
                        state_d = S_FETCH;
                    end
                    OP_HALT:  state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEM_RD: begin
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                mbr_d   = mem_data_in;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ac_d    = (opcode == OP_LOAD) ? mbr_q : alu_out;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    illegal_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // MAR is loaded on entry to any strobing state so the address is
        // stable for the whole strobe cycle.
        if (state_d == S_FETCH) begin
            mar_d = ADDR_WIDTH'(pc_d);
        end else if (state_d == S_MEM_RD || state_d == S_MEM_WR) begin
            mar_d = ADDR_WIDTH'(operand);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mbr_q     <= '0;
            ac_q      <= '0;
            mar_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mbr_q     <= mbr_d;
            ac_q      <= ac_d;
            mar_q     <= mar_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are masked by rst so a write coinciding with a reset edge never
    // reaches the RAM.
    assign strobe_rd    = (state_q == S_FETCH) || (state_q == S_MEM_RD);
    assign strobe_wr    = (state_q == S_MEM_WR);
    assign mem_cs       = (strobe_rd || strobe_wr) && !rst;
    assign mem_oe       = strobe_rd && !rst;
    assign mem_we       = strobe_wr && !rst;
    assign mem_data_out = mem_we ? ac_q : '0;
    assign mem_addr     = mar_q;

    // ADD/SUB/AND/OR are consecutive opcodes, so the select is opcode-3.
    always_comb begin
        alu_sel = 2'b00;
        if (opcode >= OP_ADD && opcode <= OP_OR) alu_sel = 2'(opcode - OP_ADD);
    end

    assign alu_a   = ac_q;
    assign alu_b   = mbr_q;
    assign pc      = pc_q;
    assign ac      = 16'(ac_q);
    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] mem_data_in;
    logic          mem_cs, mem_we, mem_oe;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [1:0]    alu_sel;
    logic [15:0]   pc, ac;
    logic          busy, halted, illegal;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(16'h0100)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .pc(pc), .ac(ac), .busy(busy), .halted(halted), .illegal(illegal)
    );

    // Synchronous RAM, one-cycle read latency
    logic [15:0] ram [0:65535];
    logic [15:0] rdata;
    assign mem_data_in = rdata;
    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr[15:0]] <= mem_data_out;
        if (mem_cs && mem_oe) rdata <= ram[mem_addr[15:0]];
    end

    // External ALU
    always_comb begin
        case (alu_sel)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a - alu_b;
            2'b10:   alu_out = alu_a & alu_b;
            default: alu_out = alu_a | alu_b;
        endcase
    end

    // Bus activity monitor
    int we_cnt = 0, both_cnt = 0, hi_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_we && mem_oe) both_cnt <= both_cnt + 1;
        if (mem_cs && mem_addr[AW-1:16] != '0) hi_cnt <= hi_cnt + 1;
    end

    // Reference model memory (ISA-level view)
    logic [15:0] rm [0:65535];

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            ram[16'(i)] <= 16'h0000;
            rm[16'(i)] = 16'h0000;
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        ram[a] <= d;
        rm[a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse start, then count edges until halted (bounded). Optionally sprays
    // start pulses while the core is busy.
    task automatic run(input bit noise, input int probe, output logic [15:0] probe_pc,
                       output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        probe_pc = 16'hxxxx;
        while (halted !== 1'b1) begin
            if (cyc >= 400) break;
            if (noise) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == probe) probe_pc = pc;
        end
    endtask

    // Instruction-set interpreter: executes from mpc until HALT or illegal.
    task automatic model_run(inout logic [15:0] mpc, inout logic [15:0] mac,
                             output bit mill, output int mcyc);
        logic [15:0] ins, a;
        mcyc = 0;
        mill = 1'b0;
        for (int s = 0; s < 100; s++) begin
            ins = rm[mpc];
            mpc = mpc + 16'd2;
            a = {4'h0, ins[11:0]};
            case (ins[15:12])
                4'h0: mcyc += 3;
                4'h1: begin mac = rm[a];        mcyc += 6; end
                4'h2: begin rm[a] = mac;        mcyc += 4; end
                4'h3: begin mac = mac + rm[a];  mcyc += 6; end
                4'h4: begin mac = mac - rm[a];  mcyc += 6; end
                4'h5: begin mac = mac & rm[a];  mcyc += 6; end
                4'h6: begin mac = mac | rm[a];  mcyc += 6; end
                4'h7: begin mpc = a;            mcyc += 3; end
                4'h8: begin if (mac == 16'h0) mpc = a; mcyc += 3; end
                4'h9: begin mac = a;            mcyc += 3; end
                4'hF: begin mcyc += 3; return; end
                default: begin mill = 1'b1; mcyc += 3; return; end
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (pc !== 16'h0100) begin miscompares++; $display("FAIL rst_pc: got %h want 0100", pc); end
        vectors++; if (ac !== 16'h0000) begin miscompares++; $display("FAIL rst_ac: got %h want 0000", ac); end
        vectors++; if ({busy, halted, illegal} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {busy, halted, illegal}); end
        vectors++; if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin miscompares++; $display("FAIL rst_strobes: got %b want 000", {mem_cs, mem_we, mem_oe}); end
        vectors++; if (mem_addr !== '0 || mem_data_out !== '0) begin miscompares++; $display("FAIL rst_bus: addr %h data %h want 0 0", mem_addr, mem_data_out); end
        vectors++; if (alu_sel !== 2'b00) begin miscompares++; $display("FAIL rst_alusel: got %b want 00", alu_sel); end
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_hold: busy %b want 0", busy); end
    endtask

    task automatic test_program();
        logic [15:0] pp;
        int cyc;
        do_reset();
        clear_mem();
        poke(16'h0100, 16'h1040); poke(16'h0102, 16'h3042);
        poke(16'h0104, 16'h2044); poke(16'h0106, 16'hF000);
        poke(16'h0040, 16'd5);    poke(16'h0042, 16'd7);
        run(1'b0, 0, pp, cyc);
        vectors++; if (cyc !== 19) begin miscompares++; $display("FAIL prog_cycles: got %0d want 19", cyc); end
        vectors++; if (ram[16'h0044] !== 16'd12) begin miscompares++; $display("FAIL prog_mem44: got %h want 000c", ram[16'h0044]); end
        vectors++; if (ac !== 16'd12) begin miscompares++; $display("FAIL prog_ac: got %h want 000c", ac); end
        vectors++; if (pc !== 16'h0108 || halted !== 1'b1) begin miscompares++; $display("FAIL prog_pc: pc %h halted %b want 0108 1", pc, halted); end
    endtask

    task automatic test_jz();
        logic [15:0] pp;
        int cyc;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            clear_mem();
            poke(16'h0100, (k == 0) ? 16'h9000 : 16'h9001);
            poke(16'h0102, 16'h8120); poke(16'h0104, 16'hF000);
            poke(16'h0120, 16'h9ABC); poke(16'h0122, 16'hF000);
            run(1'b0, 6, pp, cyc);
            vectors++; if (pp !== ((k == 0) ? 16'h0120 : 16'h0104)) begin miscompares++; $display("FAIL jz_pc%0d: got %h want %h", k, pp, (k == 0) ? 16'h0120 : 16'h0104); end
            vectors++; if (ac !== ((k == 0) ? 16'h0ABC : 16'h0001)) begin miscompares++; $display("FAIL jz_ac%0d: got %h", k, ac); end
            vectors++; if (cyc !== ((k == 0) ? 12 : 9)) begin miscompares++; $display("FAIL jz_cycles%0d: got %0d want %0d", k, cyc, (k == 0) ? 12 : 9); end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] pp;
        int cyc, we0;
        do_reset();
        clear_mem();
        poke(16'h0100, 16'hB000); poke(16'h0102, 16'h9055); poke(16'h0104, 16'hF000);
        we0 = we_cnt;
        run(1'b0, 0, pp, cyc);
        vectors++; if (cyc !== 3) begin miscompares++; $display("FAIL ill_cycles: got %0d want 3", cyc); end
        vectors++; if ({illegal, halted} !== 2'b11) begin miscompares++; $display("FAIL ill_flags: got %b want 11", {illegal, halted}); end
        repeat (3) @(negedge clk);
        vectors++; if (pc !== 16'h0102 || halted !== 1'b1 || mem_cs !== 1'b0) begin miscompares++; $display("FAIL halt_hold: pc %h halted %b cs %b", pc, halted, mem_cs); end
        vectors++; if (we_cnt !== we0) begin miscompares++; $display("FAIL ill_we: %0d write strobes want 0", we_cnt - we0); end
        run(1'b0, 0, pp, cyc);
        vectors++; if (illegal !== 1'b0 || ac !== 16'h0055) begin miscompares++; $display("FAIL resume: illegal %b ac %h want 0 0055", illegal, ac); end
        vectors++; if (cyc !== 6 || pc !== 16'h0106) begin miscompares++; $display("FAIL resume_pc: cyc %0d pc %h want 6 0106", cyc, pc); end
    endtask

    task automatic test_arith();
        logic [15:0] pp;
        int cyc;
        do_reset();
        clear_mem();
        poke(16'h0100, 16'h1040); poke(16'h0102, 16'h3042); poke(16'h0104, 16'h2046);
        poke(16'h0106, 16'h9000); poke(16'h0108, 16'h4044); poke(16'h010A, 16'hF000);
        poke(16'h0040, 16'hFFFF); poke(16'h0042, 16'h0002); poke(16'h0044, 16'h0001);
        run(1'b1, 0, pp, cyc);
        vectors++; if (ram[16'h0046] !== 16'h0001) begin miscompares++; $display("FAIL add_wrap: got %h want 0001", ram[16'h0046]); end
        vectors++; if (ac !== 16'hFFFF) begin miscompares++; $display("FAIL sub_wrap: got %h want ffff", ac); end
        vectors++; if (cyc !== 28 || pc !== 16'h010C) begin miscompares++; $display("FAIL arith_cycles: cyc %0d pc %h want 28 010c", cyc, pc); end
    endtask

    task automatic test_reset_write();
        do_reset();
        clear_mem();
        poke(16'h0100, 16'h9123); poke(16'h0102, 16'h2050); poke(16'h0050, 16'hBEEF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        vectors++; if ({mem_cs, mem_we, mem_oe} !== 3'b110 || mem_addr !== 18'h00050 || mem_data_out !== 16'h0123) begin miscompares++; $display("FAIL wr_strobe: cs/we/oe %b addr %h data %h want 110 00050 0123", {mem_cs, mem_we, mem_oe}, mem_addr, mem_data_out); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (mem_we !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL wr_abort: we %b busy %b want 0 0", mem_we, busy); end
        vectors++; if (pc !== 16'h0100 || ac !== 16'h0000) begin miscompares++; $display("FAIL wr_abort_regs: pc %h ac %h want 0100 0000", pc, ac); end
        @(negedge clk);
        vectors++; if (ram[16'h0050] !== 16'hBEEF) begin miscompares++; $display("FAIL wr_abort_mem: got %h want beef", ram[16'h0050]); end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_over_start: busy %b want 0", busy); end
    endtask

    task automatic test_random();
        logic [15:0] pp, mpc, mac, ins;
        logic [3:0]  op;
        bit          mill;
        int          cyc, mcyc, n, bad;
        for (int t = 0; t < 40; t++) begin
            do_reset();
            clear_mem();
            for (int a = 0; a < 256; a++) poke(16'(a), 16'($urandom));
            n = $urandom_range(3, 10);
            for (int i = 0; i < n; i++) begin
                if (i == n - 1) begin
                    ins = 16'hF000;
                end else begin
                    op = 4'($urandom_range(0, 9));
                    if ($urandom_range(0, 19) == 0) op = 4'($urandom_range(10, 14));
                    case (op)
                        4'h7, 4'h8: ins = {op, 12'(16'h0100 + 16'(2 * $urandom_range(i + 1, n - 1)))};
                        4'h9:       ins = {op, ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom)};
                        default:    ins = {op, 12'($urandom_range(0, 255))};
                    endcase
                end
                poke(16'(16'h0100 + 2 * i), ins);
            end
            mpc = 16'h0100;
            mac = 16'h0000;
            model_run(mpc, mac, mill, mcyc);
            run(1'b1, 0, pp, cyc);
            vectors++; if (cyc !== mcyc) begin miscompares++; $display("FAIL rnd%0d_cycles: got %0d want %0d", t, cyc, mcyc); end
            vectors++; if (ac !== mac) begin miscompares++; $display("FAIL rnd%0d_ac: got %h want %h", t, ac, mac); end
            vectors++; if (pc !== mpc) begin miscompares++; $display("FAIL rnd%0d_pc: got %h want %h", t, pc, mpc); end
            vectors++; if (illegal !== mill) begin miscompares++; $display("FAIL rnd%0d_illegal: got %b want %b", t, illegal, mill); end
            bad = 0;
            for (int a = 0; a < 512; a++) if (ram[16'(a)] !== rm[16'(a)]) bad++;
            vectors++; if (bad != 0) begin miscompares++; $display("FAIL rnd%0d_mem: %0d words differ, want 0", t, bad); end
        end
    endtask

    task automatic test_protocol();
        vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL we_oe_both: got %0d want 0", both_cnt); end
        vectors++; if (hi_cnt !== 0) begin miscompares++; $display("FAIL addr_high: got %0d want 0", hi_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rdata = 16'h0000;
        clear_mem();
        test_reset();
        test_program();
        test_jz();
        test_illegal();
        test_arith();
        test_reset_write();
        test_random();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
